pixel_row_readout_buffer: RTL and testbench
===========================================

# pixel_row_readout_buffer

Double-buffered row readout stage between the pixel array and the output bus. Captures a complete digitised row of `ROW_WIDTH` pixels in one cycle, then streams it out `BUS_PIXELS` pixels per beat over a valid/ready interface. Supports a full-resolution mode and a horizontal decimate-by-2 mode, and counts rows dropped when both banks are occupied. It generalises the fixed array-width/bus-width relationship in `PixelSensorConfig`.

## Interface

Parameters:
- `ROW_WIDTH`, default `PixelSensorConfig::PIXEL_ARRAY_WIDTH` (128): pixels per row.
- `PIXEL_BITS`, default `PixelSensorConfig::PIXEL_BITS` (8): bits per pixel.
- `BUS_PIXELS`, default `PixelSensorConfig::OUTPUT_BUS_WIDTH` (8): pixels per output beat.
- `DROP_CNT_BITS`, default 8: width of the drop counter.
- Constraint: `ROW_WIDTH % (2*BUS_PIXELS) == 0`. Elaboration fails otherwise.

Ports:
- `clk`  in  1  single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mode`  in  1  `readout_mode_t`: `READOUT_FULL`=0, `READOUT_DECIM2`=1.
- `in_valid`  in  1  row present on `in_row`.
- `in_ready`  out  1  a free bank exists.
- `in_row`  in  `ROW_WIDTH*PIXEL_BITS`  pixel i occupies bits `[i*PIXEL_BITS +: PIXEL_BITS]`.
- `out_valid`  out  1  beat available.
- `out_ready`  in  1  downstream accepts the beat.
- `out_data`  out  `BUS_PIXELS*PIXEL_BITS`  beat pixels, with lowest index in the LSBs.
- `out_first` / `out_last`  out  1  first or last beat of a row. Both are qualified by `out_valid`.
- `row_dropped`  out  1  one-cycle pulse when a row was offered while `in_ready`=0.
- `drop_count`  out  `DROP_CNT_BITS`  saturating count of dropped rows.
- `drop_clear`  in  1  synchronous clear of `drop_count`.

## Operation

Banks:
- There are two banks. Each bank holds one row, a `full` flag, and the `mode` latched at capture.

Write side:
- Write pointer `wp` selects the target bank. `in_ready = !full[wp]`.
- On `in_valid && in_ready`, store `in_row` and `mode` into bank `wp`, set `full[wp]`, and toggle `wp`.

Drops:
- When `in_valid && !in_ready`, the row is discarded and `row_dropped` pulses.
- `drop_count` increments and saturates at all-ones.
- `drop_clear` has priority over a simultaneous increment. The result is 0, and the pulse is still emitted.

Read side:
- Read pointer `rp` selects the bank being read. `out_valid = full[rp]`. The beat index is `beat`.
- In `READOUT_FULL` there are `ROW_WIDTH/BUS_PIXELS` beats. Beat b carries pixels `b*BUS_PIXELS .. b*BUS_PIXELS+BUS_PIXELS-1`.
- In `READOUT_DECIM2` there are `ROW_WIDTH/(2*BUS_PIXELS)` beats. Beat b carries even pixels `2*(b*BUS_PIXELS+k)` for k = 0..BUS_PIXELS-1.
- `out_first = (beat==0)`. `out_last = (beat==last_beat(bank mode))`.
- A handshake occurs on `out_valid && out_ready`:
  - If not last: `beat++`.
  - If last: `beat<=0`, clear `full[rp]`, toggle `rp`.

Mode and handshake rules:
- Changing `mode` never affects a row already captured.
- While `out_valid && !out_ready`, `out_data`, `out_first` and `out_last` hold stable.

Simultaneous events:
- Capture into one bank and release of the other bank in the same cycle both take effect.
- A bank freed by the last beat is not writable until the next cycle, because `in_ready` is evaluated from the state before the edge.

## Timing

Reset values (while `reset_n`=0):
- Both `full`=0, `wp`=`rp`=0, `beat`=0, `drop_count`=0.
- `out_valid`=0, `out_first` reads 1 but is unqualified, `out_last`=0.
- `in_ready`=1, `row_dropped`=0.
- Bank data is not reset.

Reset mid-operation:
- Stored rows are discarded.
- No partial-row beats follow reset release.

Latency and throughput:
- A row captured at edge N gives `out_valid`=1 in cycle N+1 (one-cycle latency).
- Full-rate streaming sustains 1 beat per cycle with `out_ready` tied high.
- Capture is 1 row per cycle while a bank is free.

Output timing:
- `out_data` is a mux of registered bank contents selected by registered `rp`/`beat`. There is no combinational path from `in_*` to `out_*`.
- `in_ready` depends only on registered state, never on `out_ready`.

## Structure

Additions to `PixelSensorConfig`:
- `readout_mode_t` enum.
- `function automatic int beats_per_row(int width, int bus, readout_mode_t m)`.
- `localparam BEAT_IDX_BITS` sized for `READOUT_FULL`.

Sub-module:
- `pixel_row_bank` (×2): row register, `full` flag, and latched mode.
- It has set/clear controls and a beat-select output mux parameterised by `BUS_PIXELS` and mode.

## Test plan

1. Reset, then one row with pixel i = i, `READOUT_FULL`, `out_ready`=1 -> 16 beats on consecutive cycles.
   - Beat 0 = {7..0}, beat 15 = {127..120}.
   - `out_first` on beat 0 only, `out_last` on beat 15 only.
2. Same row in `READOUT_DECIM2` -> 8 beats. Beat 0 = {14,12,..,0}, beat 7 = {126,..,112}.
3. `out_ready`=0 with three rows offered on consecutive cycles -> first two captured, third gives `row_dropped` pulse and `drop_count`=1. `in_ready`=0 until a last beat is accepted.
4. Random `out_ready` backpressure over 100 rows -> data stable while stalled, no loss, rows in order.
5. 300 drops -> `drop_count` saturates at 255. `drop_clear` coincident with a drop -> 0.
6. Assert `reset_n`=0 mid-row (beat 5) -> `out_valid`=0 immediately and `in_ready`=1. After release, no beats until a new row arrives.

Source files
------------

// File: rtl/pixel_row_readout_buffer_pkg.sv
// PixelSensorConfig: shared sensor geometry, the readout mode type, and a
// helper for beat counts. The pixel row readout buffer and its bank
// sub-module use these definitions.
package PixelSensorConfig;

  localparam int PIXEL_ARRAY_WIDTH = 128;
  localparam int PIXEL_BITS        = 8;
  localparam int OUTPUT_BUS_WIDTH  = 8;

  typedef enum logic {
    READOUT_FULL   = 1'b0,
    READOUT_DECIM2 = 1'b1
  } readout_mode_t;

  // Number of output beats needed to stream one row in the given mode.
  function automatic int beats_per_row(int width, int bus, readout_mode_t m);
    return (m == READOUT_DECIM2) ? width / (2 * bus) : width / bus;
  endfunction

  // Beat index width, sized for full-resolution readout (the longest case).
  localparam int BEAT_IDX_BITS =
    (beats_per_row(PIXEL_ARRAY_WIDTH, OUTPUT_BUS_WIDTH, READOUT_FULL) > 1) ?
    $clog2(beats_per_row(PIXEL_ARRAY_WIDTH, OUTPUT_BUS_WIDTH, READOUT_FULL)) : 1;

endpackage

// File: rtl/pixel_row_readout_buffer_bank.sv
// pixel_row_bank: one row-storage bank of the readout buffer.
// Holds a captured row, its full flag and the readout mode latched at capture,
// and muxes out the pixels of the selected beat.
//   clk, reset_n  : clock, asynchronous active-low reset (clears full/mode)
//   set           : capture row_in/mode_in and mark the bank full
//   clr           : mark the bank empty (last beat accepted)
//   row_in        : full row, pixel i at [i*PIXEL_BITS +: PIXEL_BITS]
//   mode_in       : readout mode to latch with the row
//   beat          : beat index to present on beat_data
//   full          : bank holds an unread row
//   mode          : latched readout mode
//   beat_data     : BUS_PIXELS pixels of the selected beat, lowest in LSBs
module pixel_row_bank #(
  parameter int ROW_WIDTH  = 128,
  parameter int PIXEL_BITS = 8,
  parameter int BUS_PIXELS = 8,
  parameter int BEAT_BITS  = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             set,
  input  logic                             clr,
  input  logic [ROW_WIDTH*PIXEL_BITS-1:0]  row_in,
  input  logic                             mode_in,
  input  logic [BEAT_BITS-1:0]             beat,
  output logic                             full,
  output logic                             mode,
  output logic [BUS_PIXELS*PIXEL_BITS-1:0] beat_data
);
  import PixelSensorConfig::readout_mode_t;
  import PixelSensorConfig::READOUT_FULL;
  import PixelSensorConfig::READOUT_DECIM2;

  logic [ROW_WIDTH*PIXEL_BITS-1:0] row_q;
  readout_mode_t                   mode_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full   <= 1'b0;
      mode_q <= READOUT_FULL;
    end else if (set) begin
      full   <= 1'b1;
      mode_q <= readout_mode_t'(mode_in);
    end else if (clr) begin
      full   <= 1'b0;
    end
  end

  // Row storage is deliberately not reset; it is only meaningful while full.
  always_ff @(posedge clk) begin
    if (set) begin
      row_q <= row_in;
    end
  end

  assign mode = mode_q;

  // Decimated beats pick every other pixel starting at pixel 0.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    beat_data = '0;
    for (int unsigned k = 0; k < BUS_PIXELS; k++) begin
      if (mode_q == READOUT_DECIM2) begin
        idx = 2 * (int'(beat) * BUS_PIXELS + k);
      end else begin
        idx = int'(beat) * BUS_PIXELS + k;
      end
      beat_data[k*PIXEL_BITS +: PIXEL_BITS] = row_q[idx*PIXEL_BITS +: PIXEL_BITS];
    end
  end

endmodule

// File: rtl/pixel_row_readout_buffer.sv
// pixel_row_readout_buffer: double-buffered row readout stage.
// Captures a full row in one cycle into a free bank, then streams it out
// BUS_PIXELS pixels per beat (full resolution or horizontal decimate-by-2).
// Rows offered while both banks are occupied are dropped and counted.
//   clk, reset_n          : clock, asynchronous active-low reset
//   mode                  : 0 = full resolution, 1 = decimate-by-2
//   in_valid / in_ready   : row capture handshake (in_ready = a free bank)
//   in_row                : row, pixel i at [i*PIXEL_BITS +: PIXEL_BITS]
//   out_valid / out_ready : beat handshake
//   out_data              : beat pixels, lowest index in the LSBs
//   out_first / out_last  : first / last beat of a row (qualified by out_valid)
//   row_dropped           : one-cycle pulse after a row was refused
//   drop_count            : saturating dropped-row count
//   drop_clear            : synchronous clear of drop_count (wins over increment)
module pixel_row_readout_buffer #(
  parameter int ROW_WIDTH     = PixelSensorConfig::PIXEL_ARRAY_WIDTH,
  parameter int PIXEL_BITS    = PixelSensorConfig::PIXEL_BITS,
  parameter int BUS_PIXELS    = PixelSensorConfig::OUTPUT_BUS_WIDTH,
  parameter int DROP_CNT_BITS = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             mode,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ROW_WIDTH*PIXEL_BITS-1:0]  in_row,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [BUS_PIXELS*PIXEL_BITS-1:0] out_data,
  output logic                             out_first,
  output logic                             out_last,
  output logic                             row_dropped,
  output logic [DROP_CNT_BITS-1:0]         drop_count,
  input  logic                             drop_clear
);
  import PixelSensorConfig::readout_mode_t;
  import PixelSensorConfig::READOUT_FULL;
  import PixelSensorConfig::READOUT_DECIM2;
  import PixelSensorConfig::beats_per_row;

  localparam int BEATS_FULL = beats_per_row(ROW_WIDTH, BUS_PIXELS, READOUT_FULL);
  localparam int BEATS_DEC  = beats_per_row(ROW_WIDTH, BUS_PIXELS, READOUT_DECIM2);
  localparam int BEAT_BITS  = (BEATS_FULL > 1) ? $clog2(BEATS_FULL) : 1;
  localparam logic [BEAT_BITS-1:0] LAST_FULL = BEAT_BITS'(BEATS_FULL - 1);
  localparam logic [BEAT_BITS-1:0] LAST_DEC  = BEAT_BITS'(BEATS_DEC - 1);

  if (ROW_WIDTH % (2 * BUS_PIXELS) != 0) begin : g_bad_geometry
    $error("ROW_WIDTH must be a multiple of 2*BUS_PIXELS");
  end

  logic                             wp;
  logic                             rp;
  logic [BEAT_BITS-1:0]             beat;
  logic [1:0]                       full_b;
  logic [1:0]                       mode_b;
  logic [1:0]                       set_b;
  logic [1:0]                       clr_b;
  logic [BUS_PIXELS*PIXEL_BITS-1:0] data_b [2];
  logic                             capture;
  logic                             drop;
  logic                             handshake;
  logic [BEAT_BITS-1:0]             last_beat;

  // in_ready comes only from registered state, so a bank released by this
  // cycle's last beat becomes writable on the next cycle.
  assign in_ready  = ~full_b[wp];
  assign capture   = in_valid & in_ready;
  assign drop      = in_valid & ~in_ready;

  assign out_valid = full_b[rp];
  assign out_data  = data_b[rp];
  assign last_beat = (readout_mode_t'(mode_b[rp]) == READOUT_DECIM2) ? LAST_DEC : LAST_FULL;
  assign out_first = (beat == '0);
  assign out_last  = (beat == last_beat);
  assign handshake = out_valid & out_ready;

  for (genvar i = 0; i < 2; i++) begin : g_bank
    assign set_b[i] = capture & (wp == 1'(i));
    assign clr_b[i] = handshake & out_last & (rp == 1'(i));

    pixel_row_bank #(
      .ROW_WIDTH  (ROW_WIDTH),
      .PIXEL_BITS (PIXEL_BITS),
      .BUS_PIXELS (BUS_PIXELS),
      .BEAT_BITS  (BEAT_BITS)
    ) u_bank (
      .clk       (clk),
      .reset_n   (reset_n),
      .set       (set_b[i]),
      .clr       (clr_b[i]),
      .row_in    (in_row),
      .mode_in   (mode),
      .beat      (beat),
      .full      (full_b[i]),
      .mode      (mode_b[i]),
      .beat_data (data_b[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp          <= 1'b0;
      rp          <= 1'b0;
      beat        <= '0;
      row_dropped <= 1'b0;
      drop_count  <= '0;
    end else begin
      if (capture) begin
        wp <= ~wp;
      end
      if (handshake) begin
        if (out_last) begin
          beat <= '0;
          rp   <= ~rp;
        end else begin
          beat <= beat + 1'b1;
        end
      end
      row_dropped <= drop;
      if (drop_clear) begin
        drop_count <= '0;
      end else if (drop && !(&drop_count)) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_row_readout_buffer.sv
// Self-checking bench for pixel_row_readout_buffer: a queue-based row model
// predicts every output each cycle; fixed beat tables and hand sequences
// cover the directed corner cases.
module tb_pixel_row_readout_buffer;
  localparam int RW  = 128;
  localparam int PB  = 8;
  localparam int BP  = 8;
  localparam int DCB = 8;
  localparam int RB  = RW * PB;
  localparam int DB  = BP * PB;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          mode = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [RB-1:0] in_row = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DB-1:0] out_data;
  logic          out_first;
  logic          out_last;
  logic          row_dropped;
  logic [DCB-1:0] drop_count;
  logic          drop_clear = 1'b0;

  always #5 clk = ~clk;

  pixel_row_readout_buffer #(
    .ROW_WIDTH     (RW),
    .PIXEL_BITS    (PB),
    .BUS_PIXELS    (BP),
    .DROP_CNT_BITS (DCB)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mode        (mode),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_row      (in_row),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_first   (out_first),
    .out_last    (out_last),
    .row_dropped (row_dropped),
    .drop_count  (drop_count),
    .drop_clear  (drop_clear)
  );

  typedef struct {
    logic [RB-1:0] row;
    bit            md;
  } row_t;

  typedef struct {
    bit          md;
    int          b;
    logic [63:0] data;
    bit          first;
    bit          last;
  } vec_t;

  row_t          q[$];
  int            mbeat;
  bit            exp_pulse;
  int            exp_cnt;
  int            rows_done;
  int            captured;
  int            total;
  int            passed;
  logic [DB-1:0] cap [16];
  bit            capf [16];
  bit            capl [16];
  vec_t          tbl [6];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int nbeats(bit md);
    return md ? RW / (2 * BP) : RW / BP;
  endfunction

  function automatic logic [DB-1:0] exp_beat(logic [RB-1:0] r, bit md, int b);
    logic [DB-1:0] d;
    int            p;
    d = '0;
    for (int k = 0; k < BP; k++) begin
      p = md ? 2 * (b * BP + k) : b * BP + k;
      d[k*PB +: PB] = r[p*PB +: PB];
    end
    return d;
  endfunction

  function automatic logic [RB-1:0] ramp_row();
    logic [RB-1:0] r;
    for (int i = 0; i < RW; i++) r[i*PB +: PB] = PB'(i);
    return r;
  endfunction

  function automatic logic [RB-1:0] rand_row();
    logic [RB-1:0] r;
    for (int i = 0; i < RB / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One cycle: check outputs against the model, drive inputs, then advance
  // the model to the state after the coming rising edge.
  task automatic step(bit iv, logic [RB-1:0] r, bit md, bit ordy, bit dclr);
    bit   had_room;
    row_t e;
    @(negedge clk);
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("row_dropped", 64'(row_dropped), 64'(exp_pulse));
    chk("drop_count", 64'(drop_count), 64'(exp_cnt));
    if (q.size() > 0) begin
      chk("out_data", 64'(out_data), 64'(exp_beat(q[0].row, q[0].md, mbeat)));
      chk("out_first", 64'(out_first), 64'(mbeat == 0));
      chk("out_last", 64'(out_last), 64'(mbeat == nbeats(q[0].md) - 1));
    end
    in_valid   = iv;
    in_row     = r;
    mode       = md;
    out_ready  = ordy;
    drop_clear = dclr;
    had_room   = q.size() < 2;
    if (q.size() > 0 && ordy) begin
      cap[mbeat]  = out_data;
      capf[mbeat] = out_first;
      capl[mbeat] = out_last;
      if (mbeat == nbeats(q[0].md) - 1) begin
        void'(q.pop_front());
        mbeat = 0;
        rows_done++;
      end else begin
        mbeat++;
      end
    end
    if (iv && had_room) begin
      e.row = r;
      e.md  = md;
      q.push_back(e);
      captured++;
    end
    exp_pulse = iv && !had_room;
    if (dclr) exp_cnt = 0;
    else if (exp_pulse && exp_cnt < 255) exp_cnt++;
  endtask

  task automatic model_clear();
    q.delete();
    mbeat     = 0;
    exp_pulse = 0;
    exp_cnt   = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    drop_clear = 1'b0;
    mode       = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_first", 64'(out_first), 64'(1));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_row_dropped", 64'(row_dropped), 64'(0));
    chk("rst_drop_count", 64'(drop_count), 64'(0));
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check_table(bit md);
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].md == md) begin
        chk($sformatf("tbl_data_m%0d_b%0d", md, tbl[i].b), 64'(cap[tbl[i].b]), tbl[i].data);
        chk($sformatf("tbl_first_m%0d_b%0d", md, tbl[i].b), 64'(capf[tbl[i].b]), 64'(tbl[i].first));
        chk($sformatf("tbl_last_m%0d_b%0d", md, tbl[i].b), 64'(capl[tbl[i].b]), 64'(tbl[i].last));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RB-1:0] ramp;
    int            base;
    int            cyc;
    total = 0;
    passed = 0;
    rows_done = 0;
    captured = 0;
    model_clear();
    ramp = ramp_row();

    tbl[0] = '{md: 1'b0, b: 0,  data: 64'h0706050403020100, first: 1'b1, last: 1'b0};
    tbl[1] = '{md: 1'b0, b: 1,  data: 64'h0f0e0d0c0b0a0908, first: 1'b0, last: 1'b0};
    tbl[2] = '{md: 1'b0, b: 15, data: 64'h7f7e7d7c7b7a7978, first: 1'b0, last: 1'b1};
    tbl[3] = '{md: 1'b1, b: 0,  data: 64'h0e0c0a0806040200, first: 1'b1, last: 1'b0};
    tbl[4] = '{md: 1'b1, b: 1,  data: 64'h1e1c1a1816141210, first: 1'b0, last: 1'b0};
    tbl[5] = '{md: 1'b1, b: 7,  data: 64'h7e7c7a7876747270, first: 1'b0, last: 1'b1};

    // Full-resolution ramp row, out_ready held high.
    do_reset();
    base = rows_done;
    step(1'b1, ramp, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("t1_rows", 64'(rows_done - base), 64'(1));
    check_table(1'b0);

    // Decimated ramp row; the mode input wanders after capture.
    base = rows_done;
    step(1'b1, ramp, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, '0, 1'($urandom), 1'b1, 1'b0);
    chk("t2_rows", 64'(rows_done - base), 64'(1));
    check_table(1'b1);

    // Both banks filled while stalled, third row dropped, then drain.
    do_reset();
    base = rows_done;
    step(1'b1, rand_row(), 1'b0, 1'b0, 1'b0);
    step(1'b1, rand_row(), 1'b1, 1'b0, 1'b0);
    step(1'b1, rand_row(), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("t3_pulse", 64'(row_dropped), 64'(1));
    chk("t3_drop_count", 64'(drop_count), 64'(1));
    for (int i = 0; i < 26; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("t3_rows", 64'(rows_done - base), 64'(2));

    // Random traffic and backpressure over 100 rows.
    do_reset();
    base = rows_done;
    captured = 0;
    cyc = 0;
    while (rows_done - base < 100 && cyc < 20000) begin
      step(($urandom % 3 != 0) && captured < 100, rand_row(), 1'($urandom),
           1'($urandom), 1'b0);
      cyc++;
    end
    chk("t4_rows", 64'(rows_done - base), 64'(100));

    // Drop counter saturation, then clear coincident with a drop.
    do_reset();
    step(1'b1, rand_row(), 1'b0, 1'b0, 1'b0);
    step(1'b1, rand_row(), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, rand_row(), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("t5_saturated", 64'(drop_count), 64'(255));
    step(1'b1, rand_row(), 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("t5_clear_pulse", 64'(row_dropped), 64'(1));
    chk("t5_clear_count", 64'(drop_count), 64'(0));
    for (int i = 0; i < 34; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Reset while beat 5 of a row is presented.
    do_reset();
    step(1'b1, ramp, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t6_beat5", 64'(out_data), 64'h2f2e2d2c2b2a2928);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("t6_rst_out_valid", 64'(out_valid), 64'(0));
    chk("t6_rst_in_ready", 64'(in_ready), 64'(1));
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    base = rows_done;
    step(1'b1, ramp, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("t6_rows_after", 64'(rows_done - base), 64'(1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
